// File: rtl/resonator_ddc_ctrl_pkg.sv
// Shared types and constants for the resonator DDC control-memory arbiter.
package resonator_ddc_ctrl_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef logic req_id_t;

  localparam req_id_t REQ_HOST  = 1'b0;
  localparam req_id_t REQ_SWEEP = 1'b1;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/resonator_ddc_rd_tag_pipe.sv
// Delays read tags alongside the memory read latency; the last stage lines up with valid mem_dout.
module resonator_ddc_rd_tag_pipe
  import resonator_ddc_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic in_vld,
  input  logic in_id,
  output logic out_vld,
  output logic out_id,
  output logic busy
);

  rd_tag_t stage [RD_LAT+1];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].vld <= in_vld;
      stage[0].id  <= in_id;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_vld = stage[RD_LAT].vld;
  assign out_id  = stage[RD_LAT].id;

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i <= RD_LAT; i++) begin
      busy = busy | stage[i].vld;
    end
  end

endmodule

// File: rtl/resonator_ddc_ctrl_mem_arbiter.sv
// Round-robin arbiter sharing the DDC control-memory port between host config and tone-sweep sequencer.
module resonator_ddc_ctrl_mem_arbiter
  import resonator_ddc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned STARVE_LIMIT = 1023
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  hold,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [DATA_W-1:0]     mem_dout,
  output logic [1:0]            stall,
  output logic                  busy
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  req_id_t              last_grant;
  req_id_t              win_id;
  logic [1:0]           fire;
  logic                 any_fire;
  logic                 win_we;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 tag_out_vld;
  logic                 tag_out_id;
  logic [STARVE_W-1:0]  starve_cnt [NUM_REQ];

  always_comb begin
    req_ready = '0;
    if (!hold) begin
      if (req_valid[REQ_HOST] && req_valid[REQ_SWEEP]) begin
        req_ready = (last_grant == REQ_SWEEP) ? 2'b01 : 2'b10;
      end else begin
        req_ready = req_valid;
      end
    end
  end

  assign fire      = req_valid & req_ready;
  assign any_fire  = |fire;
  assign win_id    = fire[REQ_SWEEP];
  assign win_we    = req_we[win_id];
  assign win_addr  = win_id ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
  assign win_wdata = win_id ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];

  // Address/data hold when idle; only en/we are strobes.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      last_grant <= REQ_SWEEP;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      mem_en <= any_fire;
      mem_we <= any_fire & win_we;
      if (any_fire) begin
        last_grant <= win_id;
        mem_addr   <= win_addr;
        mem_din    <= win_wdata;
      end
    end
  end

  resonator_ddc_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_vld   (any_fire & ~win_we),
    .in_id    (win_id),
    .out_vld  (tag_out_vld),
    .out_id   (tag_out_id),
    .busy     (busy)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_out_vld ? (tag_out_id ? 2'b10 : 2'b01) : 2'b00;
      if (tag_out_vld) begin
        rsp_data <= mem_dout;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        starve_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          if (starve_cnt[i] != STARVE_MAX) begin
            starve_cnt[i] <= starve_cnt[i] + 1'b1;
          end
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    stall = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      stall[i] = (starve_cnt[i] == STARVE_MAX);
    end
  end

endmodule

// File: tb/tb_resonator_ddc_ctrl_mem_arbiter.sv
// Directed bench for the DDC control-memory arbiter with a write-first, 2-cycle-latency memory model.
module tb_resonator_ddc_ctrl_mem_arbiter;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 128;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n;
  logic                hold;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic [DATA_W-1:0]   mem_dout;
  logic [1:0]          stall;
  logic                busy;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  resonator_ddc_ctrl_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RD_LAT       (2),
    .STARVE_LIMIT (1023)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .stall     (stall),
    .busy      (busy)
  );

  // Memory: word a initialised to {16{a ^ 8'hA0}}, write-first, data valid 2 cycles after mem_en.
  logic [DATA_W-1:0] mem_model [256];
  logic [DATA_W-1:0] rd1, rd2;
  logic              mem_init = 1'b0;

  always @(posedge ap_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_model[i] <= {16{i[7:0] ^ 8'hA0}};
      end
      mem_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_din;
      rd1 <= mem_we ? mem_din : mem_model[mem_addr];
    end
    rd2 <= rd1;
  end
  assign mem_dout = rd2;

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1, input logic [DATA_W-1:0] wd0);
    hold      = h;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {128'h5555_0000_5555_0000_5555_0000_5555_0000, wd0};
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);
    step();
    step();
    ap_rst_n = 1'b1;
  endtask

  typedef struct {
    logic              hold;
    logic [1:0]        valid;
    logic [1:0]        we;
    logic [7:0]        a0;
    logic [7:0]        a1;
    logic [DATA_W-1:0] wd0;
    logic [1:0]        ready;
    logic              en;
    logic              bsy;
    logic [1:0]        rv;
    logic [DATA_W-1:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic h, input logic [1:0] v, input logic [1:0] we,
                              input logic [7:0] a0, input logic [7:0] a1, input logic [DATA_W-1:0] wd0,
                              input logic [1:0] rdy, input logic en, input logic bsy,
                              input logic [1:0] rv, input logic [DATA_W-1:0] rd);
    vec_t r;
    r.hold = h; r.valid = v; r.we = we; r.a0 = a0; r.a1 = a1; r.wd0 = wd0;
    r.ready = rdy; r.en = en; r.bsy = bsy; r.rv = rv; r.rd = rd;
    return r;
  endfunction

  localparam logic [DATA_W-1:0] WD  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [DATA_W-1:0] WD2 = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

  vec_t vt [20];
  logic seen_rsp;

  initial begin
    ap_rst_n = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);

    // Reset state
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("rst req_ready", req_ready, 2'b00);
    chk("rst mem_en", mem_en, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, '0);
    chk("rst mem_din", mem_din, '0);
    chk("rst rsp_valid", rsp_valid, 2'b00);
    chk("rst rsp_data", rsp_data, '0);
    chk("rst stall", stall, 2'b00);
    chk("rst busy", busy, 1'b0);
    step();
    ap_rst_n = 1'b1;

    // Single host read of 0x05, response at fire+4
    drive(1'b0, 2'b01, 2'b00, 8'h05, 8'h00, '0);
    @(negedge ap_clk);
    chk("t1 ready", req_ready, 2'b01);
    step();
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);
    @(negedge ap_clk);
    chk("t1 mem_en", mem_en, 1'b1);
    chk("t1 mem_we", mem_we, 1'b0);
    chk("t1 mem_addr", mem_addr, 8'h05);
    step();
    step();
    @(negedge ap_clk);
    chk("t1 rsp early", rsp_valid, 2'b00);
    chk("t1 busy", busy, 1'b1);
    step();
    @(negedge ap_clk);
    chk("t1 rsp_valid", rsp_valid, 2'b01);
    chk("t1 rsp_data", rsp_data, pat(8'hA5));
    step();

    // Table: alternating conflict (write/read 0x10), back-to-back reads, hold
    do_reset();
    vt[0]  = mk(1'b0, 2'b11, 2'b01, 8'h10, 8'h10, WD,  2'b01, 1'b0, 1'b0, 2'b00, '0);
    vt[1]  = mk(1'b0, 2'b11, 2'b01, 8'h10, 8'h10, WD2, 2'b10, 1'b1, 1'b0, 2'b00, '0);
    vt[2]  = mk(1'b0, 2'b11, 2'b01, 8'h10, 8'h10, WD2, 2'b01, 1'b1, 1'b1, 2'b00, '0);
    vt[3]  = mk(1'b0, 2'b11, 2'b01, 8'h10, 8'h10, WD2, 2'b10, 1'b1, 1'b1, 2'b00, '0);
    vt[4]  = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b1, 1'b1, 2'b00, '0);
    vt[5]  = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b1, 2'b10, WD);
    vt[6]  = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b1, 2'b00, '0);
    vt[7]  = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b0, 2'b10, WD2);
    vt[8]  = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b0, 2'b00, '0);
    vt[9]  = mk(1'b0, 2'b01, 2'b00, 8'h01, 8'h00, '0,  2'b01, 1'b0, 1'b0, 2'b00, '0);
    vt[10] = mk(1'b0, 2'b10, 2'b00, 8'h00, 8'h02, '0,  2'b10, 1'b1, 1'b1, 2'b00, '0);
    vt[11] = mk(1'b0, 2'b01, 2'b00, 8'h03, 8'h00, '0,  2'b01, 1'b1, 1'b1, 2'b00, '0);
    vt[12] = mk(1'b0, 2'b10, 2'b00, 8'h00, 8'h04, '0,  2'b10, 1'b1, 1'b1, 2'b00, '0);
    vt[13] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b1, 1'b1, 2'b01, pat(8'hA1));
    vt[14] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b1, 2'b10, pat(8'hA2));
    vt[15] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b1, 2'b01, pat(8'hA3));
    vt[16] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b0, 2'b10, pat(8'hA4));
    vt[17] = mk(1'b1, 2'b11, 2'b00, 8'h08, 8'h09, '0,  2'b00, 1'b0, 1'b0, 2'b00, '0);
    vt[18] = mk(1'b1, 2'b11, 2'b00, 8'h08, 8'h09, '0,  2'b00, 1'b0, 1'b0, 2'b00, '0);
    vt[19] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0,  2'b00, 1'b0, 1'b0, 2'b00, '0);
    for (int k = 0; k < 20; k++) begin
      drive(vt[k].hold, vt[k].valid, vt[k].we, vt[k].a0, vt[k].a1, vt[k].wd0);
      @(negedge ap_clk);
      chk($sformatf("row%0d ready", k), req_ready, vt[k].ready);
      chk($sformatf("row%0d mem_en", k), mem_en, vt[k].en);
      chk($sformatf("row%0d busy", k), busy, vt[k].bsy);
      chk($sformatf("row%0d rsp_valid", k), rsp_valid, vt[k].rv);
      if (vt[k].rv != 2'b00) chk($sformatf("row%0d rsp_data", k), rsp_data, vt[k].rd);
      step();
    end

    // Sweep read held off for 1100 cycles: stall after 1023 waits, clears after fire
    drive(1'b1, 2'b10, 2'b00, 8'h00, 8'h07, '0);
    for (int i = 1; i <= 1100; i++) begin
      @(negedge ap_clk);
      if (i == 1023) chk("t3 stall before limit", stall, 2'b00);
      if (i == 1024) chk("t3 stall at limit", stall, 2'b10);
      if (i == 1100) begin
        chk("t3 ready under hold", req_ready, 2'b00);
        chk("t3 stall saturated", stall, 2'b10);
      end
      step();
    end
    hold = 1'b0;
    @(negedge ap_clk);
    chk("t3 ready after hold", req_ready, 2'b10);
    step();
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);
    @(negedge ap_clk);
    chk("t3 stall cleared", stall, 2'b00);
    chk("t3 mem_addr", mem_addr, 8'h07);
    step();
    step();
    step();
    @(negedge ap_clk);
    chk("t3 rsp_valid", rsp_valid, 2'b10);
    chk("t3 rsp_data", rsp_data, pat(8'hA7));
    step();

    // Host drops valid while starved under hold: its counter restarts
    drive(1'b1, 2'b11, 2'b00, 8'h20, 8'h21, '0);
    repeat (1020) step();
    req_valid = 2'b10;
    @(negedge ap_clk);
    chk("t6 drop mem_en", mem_en, 1'b0);
    chk("t6 drop ready", req_ready, 2'b00);
    step();
    req_valid = 2'b11;
    repeat (9) step();
    @(negedge ap_clk);
    chk("t6 stall split", stall, 2'b10);
    step();
    hold      = 1'b0;
    req_valid = 2'b10;
    @(negedge ap_clk);
    chk("t6 sweep granted", req_ready, 2'b10);
    step();
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);
    @(negedge ap_clk);
    chk("t6 mem_addr", mem_addr, 8'h21);
    chk("t6 stall cleared", stall, 2'b00);
    step();
    step();
    step();
    @(negedge ap_clk);
    chk("t6 rsp_valid", rsp_valid, 2'b10);
    chk("t6 rsp_data", rsp_data, pat(8'h81));
    step();

    // Async reset with two reads in flight
    drive(1'b0, 2'b01, 2'b00, 8'h05, 8'h00, '0);
    step();
    drive(1'b0, 2'b10, 2'b00, 8'h00, 8'h06, '0);
    step();
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);
    @(negedge ap_clk);
    chk("t5 mem_en before rst", mem_en, 1'b1);
    ap_rst_n = 1'b0;
    #1;
    chk("t5 mem_en in rst", mem_en, 1'b0);
    chk("t5 busy in rst", busy, 1'b0);
    step();
    ap_rst_n = 1'b1;
    seen_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ap_clk);
      if (rsp_valid != 2'b00) seen_rsp = 1'b1;
      step();
    end
    chk("t5 no stale rsp", seen_rsp, 1'b0);
    drive(1'b0, 2'b11, 2'b00, 8'h0A, 8'h0B, '0);
    @(negedge ap_clk);
    chk("t5 host wins after rst", req_ready, 2'b01);
    step();
    drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, '0);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
